// File: rtl/rs_station.sv
// rs_station: reservation station for the ALU path of the Tomasulo core.
//
// Holds non-memory instructions from the dispatcher until both operands are
// known. It snoops the two RS CDBs and the LS CDB to wake waiting operands, and
// issues at most one ready instruction per cycle to the ALU.
//
// Optional feature (macro RS_WAKEUP_ISSUE_EN):
//   defined   - readiness uses post-wakeup operand tags, so an entry woken at an
//               edge can issue at that same edge with the CDB value forwarded.
//   undefined - readiness uses registered tags only (one cycle later).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rdy                   global ready; low stalls the station
//   *_from_dsp            one dispatched instruction (valid, op, V1/V2, Q1/Q2, pc, imm, rob id)
//   *_from_rs_cdb1/2      result broadcast buses from the ALU side
//   *_from_ls_cdb         result broadcast bus from the load/store side
//   rollback_flag_from_rob  misprediction flush
//   full_to_if            free entries <= FULL_MARGIN, fetcher must stop
//   *_to_alu              registered issue port; ena_to_alu pulses per instruction
module rs_station #(
  parameter int unsigned RS_SIZE     = 16,
  parameter int unsigned ROB_ID_W    = 4,
  parameter int unsigned OP_W        = 6,
  parameter int unsigned FULL_MARGIN = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  input  logic                ena_from_dsp,
  input  logic [OP_W-1:0]     openum_from_dsp,
  input  logic [31:0]         V1_from_dsp,
  input  logic [31:0]         V2_from_dsp,
  input  logic [ROB_ID_W-1:0] Q1_from_dsp,
  input  logic [ROB_ID_W-1:0] Q2_from_dsp,
  input  logic [31:0]         pc_from_dsp,
  input  logic [31:0]         imm_from_dsp,
  input  logic [ROB_ID_W-1:0] rob_id_from_dsp,
  input  logic                valid_from_rs_cdb1,
  input  logic [ROB_ID_W-1:0] rob_id_from_rs_cdb1,
  input  logic [31:0]         result_from_rs_cdb1,
  input  logic                valid_from_rs_cdb2,
  input  logic [ROB_ID_W-1:0] rob_id_from_rs_cdb2,
  input  logic [31:0]         result_from_rs_cdb2,
  input  logic                valid_from_ls_cdb,
  input  logic [ROB_ID_W-1:0] rob_id_from_ls_cdb,
  input  logic [31:0]         result_from_ls_cdb,
  input  logic                rollback_flag_from_rob,
  output logic                full_to_if,
  output logic                ena_to_alu,
  output logic [OP_W-1:0]     openum_to_alu,
  output logic [31:0]         V1_to_alu,
  output logic [31:0]         V2_to_alu,
  output logic [31:0]         pc_to_alu,
  output logic [31:0]         imm_to_alu,
  output logic [ROB_ID_W-1:0] rob_id_to_alu
);

  localparam int unsigned IdxW  = $clog2(RS_SIZE);
  localparam int unsigned CntW  = $clog2(RS_SIZE + 1);
  localparam int unsigned PairW = ROB_ID_W + 32;
  localparam logic [ROB_ID_W-1:0] ZeroRob = '0;

  // Entry storage
  logic [RS_SIZE-1:0]  r_busy;
  logic [OP_W-1:0]     r_op  [RS_SIZE];
  logic [31:0]         r_v1  [RS_SIZE];
  logic [31:0]         r_v2  [RS_SIZE];
  logic [ROB_ID_W-1:0] r_q1  [RS_SIZE];
  logic [ROB_ID_W-1:0] r_q2  [RS_SIZE];
  logic [31:0]         r_pc  [RS_SIZE];
  logic [31:0]         r_imm [RS_SIZE];
  logic [ROB_ID_W-1:0] r_rob [RS_SIZE];

  // Issue port registers
  logic                r_ena_alu;
  logic [OP_W-1:0]     r_op_alu;
  logic [31:0]         r_v1_alu;
  logic [31:0]         r_v2_alu;
  logic [31:0]         r_pc_alu;
  logic [31:0]         r_imm_alu;
  logic [ROB_ID_W-1:0] r_rob_alu;

  // CDBs gathered so index 0 carries the highest match priority
  logic [2:0]               w_cdb_vld;
  logic [2:0][ROB_ID_W-1:0] w_cdb_id;
  logic [2:0][31:0]         w_cdb_res;

  assign w_cdb_vld = {valid_from_ls_cdb, valid_from_rs_cdb2, valid_from_rs_cdb1};
  assign w_cdb_id  = {rob_id_from_ls_cdb, rob_id_from_rs_cdb2, rob_id_from_rs_cdb1};
  assign w_cdb_res = {result_from_ls_cdb, result_from_rs_cdb2, result_from_rs_cdb1};

  // Returns {tag, value} after snooping the CDBs. A zero tag never matches.
  function automatic logic [PairW-1:0] snoop(
    input logic [ROB_ID_W-1:0]      q,
    input logic [31:0]              v,
    input logic [2:0]               vld,
    input logic [2:0][ROB_ID_W-1:0] ids,
    input logic [2:0][31:0]         res
  );
    logic [PairW-1:0] pair;
    pair = {q, v};
    if (q != ZeroRob) begin
      // Walk from lowest to highest priority so the highest-priority hit wins
      for (int k = 2; k >= 0; k--) begin
        if (vld[k] && (ids[k] == q)) pair = {ZeroRob, res[k]};
      end
    end
    return pair;
  endfunction

  // Post-wakeup operand state for every entry
  logic [ROB_ID_W-1:0] w_q1_nx [RS_SIZE];
  logic [ROB_ID_W-1:0] w_q2_nx [RS_SIZE];
  logic [31:0]         w_v1_nx [RS_SIZE];
  logic [31:0]         w_v2_nx [RS_SIZE];

  always_comb begin
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      {w_q1_nx[i], w_v1_nx[i]} = snoop(r_q1[i], r_v1[i], w_cdb_vld, w_cdb_id, w_cdb_res);
      {w_q2_nx[i], w_v2_nx[i]} = snoop(r_q2[i], r_v2[i], w_cdb_vld, w_cdb_id, w_cdb_res);
    end
  end

  // Incoming operands captured against the same-cycle CDBs
  logic [ROB_ID_W-1:0] w_dsp_q1;
  logic [ROB_ID_W-1:0] w_dsp_q2;
  logic [31:0]         w_dsp_v1;
  logic [31:0]         w_dsp_v2;

  assign {w_dsp_q1, w_dsp_v1} = snoop(Q1_from_dsp, V1_from_dsp, w_cdb_vld, w_cdb_id, w_cdb_res);
  assign {w_dsp_q2, w_dsp_v2} = snoop(Q2_from_dsp, V2_from_dsp, w_cdb_vld, w_cdb_id, w_cdb_res);

  // Ready vector feeding the issue selector
  logic [RS_SIZE-1:0] w_ready;

  always_comb begin
    w_ready = '0;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
`ifdef RS_WAKEUP_ISSUE_EN
      w_ready[i] = r_busy[i] && (w_q1_nx[i] == ZeroRob) && (w_q2_nx[i] == ZeroRob);
`else
      w_ready[i] = r_busy[i] && (r_q1[i] == ZeroRob) && (r_q2[i] == ZeroRob);
`endif
    end
  end

  // Lowest-index ready entry and lowest-index free slot, both from pre-edge state
  logic            w_iss_vld;
  logic [IdxW-1:0] w_iss_idx;
  logic            w_free_vld;
  logic [IdxW-1:0] w_free_idx;

  always_comb begin
    w_iss_vld  = 1'b0;
    w_iss_idx  = '0;
    w_free_vld = 1'b0;
    w_free_idx = '0;
    for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_iss_vld = 1'b1;
        w_iss_idx = IdxW'(i);
      end
      if (!r_busy[i]) begin
        w_free_vld = 1'b1;
        w_free_idx = IdxW'(i);
      end
    end
  end

  // Occupancy and nearly-full flag
  logic [CntW-1:0] w_busy_cnt;

  always_comb begin
    w_busy_cnt = '0;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      w_busy_cnt = w_busy_cnt + CntW'(r_busy[i]);
    end
  end

  assign full_to_if = (CntW'(RS_SIZE) - w_busy_cnt) <= CntW'(FULL_MARGIN);

  logic w_dsp_do;
  assign w_dsp_do = ena_from_dsp && w_free_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= '0;
      r_ena_alu <= 1'b0;
      r_op_alu  <= '0;
      r_v1_alu  <= '0;
      r_v2_alu  <= '0;
      r_pc_alu  <= '0;
      r_imm_alu <= '0;
      r_rob_alu <= '0;
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        r_op[i]  <= '0;
        r_v1[i]  <= '0;
        r_v2[i]  <= '0;
        r_q1[i]  <= '0;
        r_q2[i]  <= '0;
        r_pc[i]  <= '0;
        r_imm[i] <= '0;
        r_rob[i] <= '0;
      end
    end else if (rollback_flag_from_rob) begin
      // Flush wins over stall, dispatch and issue
      r_busy    <= '0;
      r_ena_alu <= 1'b0;
    end else if (!rdy) begin
      r_ena_alu <= 1'b0;
    end else begin
      // Wakeup; only meaningful for busy entries, harmless for free ones
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        r_q1[i] <= w_q1_nx[i];
        r_q2[i] <= w_q2_nx[i];
        r_v1[i] <= w_v1_nx[i];
        r_v2[i] <= w_v2_nx[i];
      end

      r_ena_alu <= w_iss_vld;
      if (w_iss_vld) begin
        r_op_alu            <= r_op[w_iss_idx];
        r_v1_alu            <= w_v1_nx[w_iss_idx];
        r_v2_alu            <= w_v2_nx[w_iss_idx];
        r_pc_alu            <= r_pc[w_iss_idx];
        r_imm_alu           <= r_imm[w_iss_idx];
        r_rob_alu           <= r_rob[w_iss_idx];
        r_busy[w_iss_idx]   <= 1'b0;
      end

      // Free slot is never the issuing slot, so these writes cannot collide
      if (w_dsp_do) begin
        r_busy[w_free_idx] <= 1'b1;
        r_op[w_free_idx]   <= openum_from_dsp;
        r_v1[w_free_idx]   <= w_dsp_v1;
        r_v2[w_free_idx]   <= w_dsp_v2;
        r_q1[w_free_idx]   <= w_dsp_q1;
        r_q2[w_free_idx]   <= w_dsp_q2;
        r_pc[w_free_idx]   <= pc_from_dsp;
        r_imm[w_free_idx]  <= imm_from_dsp;
        r_rob[w_free_idx]  <= rob_id_from_dsp;
      end
    end
  end

  assign ena_to_alu    = r_ena_alu;
  assign openum_to_alu = r_op_alu;
  assign V1_to_alu     = r_v1_alu;
  assign V2_to_alu     = r_v2_alu;
  assign pc_to_alu     = r_pc_alu;
  assign imm_to_alu    = r_imm_alu;
  assign rob_id_to_alu = r_rob_alu;

endmodule

// File: tb/tb_rs_station.sv
// Testbench for rs_station: directed scenarios plus randomized traffic, checked
// by a scoreboard fed from a behavioural model of the station.
module tb_rs_station;

  localparam int RS = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        ena_from_dsp = 1'b0;
  logic [5:0]  openum_from_dsp = '0;
  logic [31:0] V1_from_dsp = '0, V2_from_dsp = '0, pc_from_dsp = '0, imm_from_dsp = '0;
  logic [3:0]  Q1_from_dsp = '0, Q2_from_dsp = '0, rob_id_from_dsp = '0;
  logic        valid_from_rs_cdb1 = 1'b0, valid_from_rs_cdb2 = 1'b0, valid_from_ls_cdb = 1'b0;
  logic [3:0]  rob_id_from_rs_cdb1 = '0, rob_id_from_rs_cdb2 = '0, rob_id_from_ls_cdb = '0;
  logic [31:0] result_from_rs_cdb1 = '0, result_from_rs_cdb2 = '0, result_from_ls_cdb = '0;
  logic        rollback_flag_from_rob = 1'b0;
  logic        full_to_if, ena_to_alu;
  logic [5:0]  openum_to_alu;
  logic [31:0] V1_to_alu, V2_to_alu, pc_to_alu, imm_to_alu;
  logic [3:0]  rob_id_to_alu;

  always #5 clk = ~clk;

  rs_station dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .rdy                    (rdy),
    .ena_from_dsp           (ena_from_dsp),
    .openum_from_dsp        (openum_from_dsp),
    .V1_from_dsp            (V1_from_dsp),
    .V2_from_dsp            (V2_from_dsp),
    .Q1_from_dsp            (Q1_from_dsp),
    .Q2_from_dsp            (Q2_from_dsp),
    .pc_from_dsp            (pc_from_dsp),
    .imm_from_dsp           (imm_from_dsp),
    .rob_id_from_dsp        (rob_id_from_dsp),
    .valid_from_rs_cdb1     (valid_from_rs_cdb1),
    .rob_id_from_rs_cdb1    (rob_id_from_rs_cdb1),
    .result_from_rs_cdb1    (result_from_rs_cdb1),
    .valid_from_rs_cdb2     (valid_from_rs_cdb2),
    .rob_id_from_rs_cdb2    (rob_id_from_rs_cdb2),
    .result_from_rs_cdb2    (result_from_rs_cdb2),
    .valid_from_ls_cdb      (valid_from_ls_cdb),
    .rob_id_from_ls_cdb     (rob_id_from_ls_cdb),
    .result_from_ls_cdb     (result_from_ls_cdb),
    .rollback_flag_from_rob (rollback_flag_from_rob),
    .full_to_if             (full_to_if),
    .ena_to_alu             (ena_to_alu),
    .openum_to_alu          (openum_to_alu),
    .V1_to_alu              (V1_to_alu),
    .V2_to_alu              (V2_to_alu),
    .pc_to_alu              (pc_to_alu),
    .imm_to_alu             (imm_to_alu),
    .rob_id_to_alu          (rob_id_to_alu)
  );

  typedef struct packed {
    logic        busy;
    logic [5:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [3:0]  q1;
    logic [3:0]  q2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  rob;
  } ent_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  rob;
  } iss_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  ent_t m  [RS];
  ent_t nx [RS];
  iss_t exp_q[$];
  int   m_sel, m_free;

  // Operand value after looking at the buses: first match in CDB1, CDB2, LS order.
  function automatic logic [35:0] snoop(input logic [3:0] q, input logic [31:0] v);
    if (q == 4'd0) return {q, v};
    if (valid_from_rs_cdb1 && rob_id_from_rs_cdb1 == q) return {4'd0, result_from_rs_cdb1};
    if (valid_from_rs_cdb2 && rob_id_from_rs_cdb2 == q) return {4'd0, result_from_rs_cdb2};
    if (valid_from_ls_cdb  && rob_id_from_ls_cdb  == q) return {4'd0, result_from_ls_cdb};
    return {q, v};
  endfunction

  function automatic logic exp_full();
    int c = 0;
    for (int i = 0; i < RS; i++) c += int'(m[i].busy);
    return (RS - c) <= 2;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RS; i++) m[i] = '0;
      exp_q.delete();
    end else if (rollback_flag_from_rob) begin
      for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < RS; i++) begin
        nx[i] = m[i];
        if (m[i].busy) begin
          {nx[i].q1, nx[i].v1} = snoop(m[i].q1, m[i].v1);
          {nx[i].q2, nx[i].v2} = snoop(m[i].q2, m[i].v2);
        end
      end
      m_sel = -1;
      for (int i = 0; i < RS; i++) begin
`ifdef RS_WAKEUP_ISSUE_EN
        if (m_sel < 0 && m[i].busy && nx[i].q1 == 0 && nx[i].q2 == 0) m_sel = i;
`else
        if (m_sel < 0 && m[i].busy && m[i].q1 == 0 && m[i].q2 == 0) m_sel = i;
`endif
      end
      if (m_sel >= 0) begin
        exp_q.push_back({nx[m_sel].op, nx[m_sel].v1, nx[m_sel].v2, nx[m_sel].pc,
                         nx[m_sel].imm, nx[m_sel].rob});
        nx[m_sel].busy = 1'b0;
      end
      m_free = -1;
      for (int i = 0; i < RS; i++) if (m_free < 0 && !m[i].busy) m_free = i;
      if (ena_from_dsp && m_free >= 0) begin
        nx[m_free].busy = 1'b1;
        nx[m_free].op   = openum_from_dsp;
        {nx[m_free].q1, nx[m_free].v1} = snoop(Q1_from_dsp, V1_from_dsp);
        {nx[m_free].q2, nx[m_free].v2} = snoop(Q2_from_dsp, V2_from_dsp);
        nx[m_free].pc   = pc_from_dsp;
        nx[m_free].imm  = imm_from_dsp;
        nx[m_free].rob  = rob_id_from_dsp;
      end
      for (int i = 0; i < RS; i++) m[i] = nx[i];
    end
  end

  // ---------------- monitor ----------------
  iss_t last = '0;
  iss_t mon_d, mon_e;

  always @(negedge clk) begin
    mon_d = {openum_to_alu, V1_to_alu, V2_to_alu, pc_to_alu, imm_to_alu, rob_id_to_alu};
    if (!rst_n) last = '0;
    if (ena_to_alu === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_issue: got rob %0d, expected no issue (t=%0t)",
                 rob_id_to_alu, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("issue", 160'(mon_d), 160'(mon_e));
        last = mon_e;
      end
    end else begin
      if (exp_q.size() != 0) begin
        n_chk++;
        $display("FAIL missing_issue: got ena_to_alu=%b, expected issue of rob %0d (t=%0t)",
                 ena_to_alu, exp_q[0].rob, $time);
        exp_q.delete();
      end else begin
        chk("hold", 160'(mon_d), 160'(last));
      end
    end
    chk("full", 160'(full_to_if), 160'(exp_full()));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    rdy = 1'b1;
    ena_from_dsp = 1'b0;
    valid_from_rs_cdb1 = 1'b0;
    valid_from_rs_cdb2 = 1'b0;
    valid_from_ls_cdb = 1'b0;
    rollback_flag_from_rob = 1'b0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                      input logic [3:0] q1, input logic [3:0] q2, input logic [3:0] rob);
    ena_from_dsp    = 1'b1;
    openum_from_dsp = op;
    V1_from_dsp     = v1;
    V2_from_dsp     = v2;
    Q1_from_dsp     = q1;
    Q2_from_dsp     = q2;
    pc_from_dsp     = $urandom;
    imm_from_dsp    = $urandom;
    rob_id_from_dsp = rob;
  endtask

  logic [3:0] id1, id2, id3;

  initial begin
    // Reset state
    idle();
    rst_n = 1'b0;
    tick();
    chk("reset_ena", 160'(ena_to_alu), 160'(1'b0));
    chk("reset_full", 160'(full_to_if), 160'(1'b0));
    tick();
    #2 rst_n = 1'b1;
    tick();

    // Fully ready dispatch issues one edge later, for one cycle
    disp(6'h01, 32'd5, 32'd7, 4'd0, 4'd0, 4'd3);
    tick();
    idle();
    tick();
    chk("ready_ena", 160'(ena_to_alu), 160'(1'b1));
    chk("ready_v1", 160'(V1_to_alu), 160'(32'd5));
    chk("ready_v2", 160'(V2_to_alu), 160'(32'd7));
    chk("ready_rob", 160'(rob_id_to_alu), 160'(4'd3));
    tick();
    chk("ready_drop", 160'(ena_to_alu), 160'(1'b0));

    // Wakeup through CDB2
    disp(6'h02, 32'hAAAA, 32'd1, 4'd4, 4'd0, 4'd7);
    tick();
    idle();
    tick();
    tick();
    valid_from_rs_cdb2 = 1'b1;
    rob_id_from_rs_cdb2 = 4'd4;
    result_from_rs_cdb2 = 32'h1234;
    tick();
    idle();
`ifndef RS_WAKEUP_ISSUE_EN
    chk("wake_not_yet", 160'(ena_to_alu), 160'(1'b0));
    tick();
`endif
    chk("wake_ena", 160'(ena_to_alu), 160'(1'b1));
    chk("wake_v1", 160'(V1_to_alu), 160'(32'h1234));
    tick();

    // Same-cycle capture from the LS CDB
    disp(6'h03, 32'd9, 32'h0, 4'd0, 4'd6, 4'd8);
    valid_from_ls_cdb = 1'b1;
    rob_id_from_ls_cdb = 4'd6;
    result_from_ls_cdb = 32'hDEAD;
    tick();
    idle();
    chk("capture_wait", 160'(ena_to_alu), 160'(1'b0));
    tick();
    chk("capture_ena", 160'(ena_to_alu), 160'(1'b1));
    chk("capture_v2", 160'(V2_to_alu), 160'(32'hDEAD));
    tick();

    // Fill 14 entries, wake 5 and 2 together: 2 first, then 5
    for (int i = 0; i < 14; i++) begin
      disp(6'h04, $urandom, $urandom, (i == 2) ? 4'd10 : (i == 5) ? 4'd11 : 4'd15, 4'd0,
           4'(i));
      tick();
    end
    idle();
    chk("fill_full", 160'(full_to_if), 160'(1'b1));
    valid_from_rs_cdb2 = 1'b1;
    rob_id_from_rs_cdb2 = 4'd11;
    result_from_rs_cdb2 = 32'h5555;
    valid_from_rs_cdb1 = 1'b1;
    rob_id_from_rs_cdb1 = 4'd10;
    result_from_rs_cdb1 = 32'h2222;
    tick();
    idle();
`ifndef RS_WAKEUP_ISSUE_EN
    chk("order_wait", 160'(ena_to_alu), 160'(1'b0));
    tick();
`endif
    chk("order_first", 160'(rob_id_to_alu), 160'(4'd2));
    chk("order_first_v1", 160'(V1_to_alu), 160'(32'h2222));
    chk("order_full_drop", 160'(full_to_if), 160'(1'b0));
    tick();
    chk("order_second", 160'(rob_id_to_alu), 160'(4'd5));
    chk("order_second_v1", 160'(V1_to_alu), 160'(32'h5555));
    rollback_flag_from_rob = 1'b1;
    tick();
    idle();

    // Rollback with blocked entries, a ready entry and a dispatch in the same cycle
    for (int i = 0; i < 8; i++) begin
      disp(6'h05, $urandom, $urandom, 4'd15, 4'd0, 4'(i + 1));
      tick();
    end
    disp(6'h06, 32'd1, 32'd2, 4'd0, 4'd0, 4'd12);
    tick();
    disp(6'h07, 32'd3, 32'd4, 4'd0, 4'd0, 4'd13);
    rollback_flag_from_rob = 1'b1;
    tick();
    idle();
    chk("rollback_ena", 160'(ena_to_alu), 160'(1'b0));
    valid_from_rs_cdb1 = 1'b1;
    rob_id_from_rs_cdb1 = 4'd15;
    result_from_rs_cdb1 = 32'h0F0F;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rollback_empty", 160'(ena_to_alu), 160'(1'b0));
    end

    // Asynchronous reset mid-run with 3 busy entries and an issue in flight
    for (int i = 0; i < 3; i++) begin
      disp(6'h08, $urandom, $urandom, 4'd15, 4'd0, 4'(i + 1));
      tick();
    end
    disp(6'h09, 32'd77, 32'd88, 4'd0, 4'd0, 4'd9);
    tick();
    idle();
    tick();
    chk("pre_reset_ena", 160'(ena_to_alu), 160'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_ena", 160'(ena_to_alu), 160'(1'b0));
    chk("midreset_full", 160'(full_to_if), 160'(1'b0));
    chk("midreset_v1", 160'(V1_to_alu), 160'(32'd0));
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    valid_from_rs_cdb1 = 1'b1;
    rob_id_from_rs_cdb1 = 4'd15;
    result_from_rs_cdb1 = 32'h0F0F;
    tick();
    idle();
    tick();
    tick();
    chk("post_reset_idle", 160'(ena_to_alu), 160'(1'b0));

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      rdy = ($urandom_range(0, 9) != 0);
      rollback_flag_from_rob = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 1) == 1) begin
        disp(6'($urandom), $urandom, $urandom,
             ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0,
             ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
             4'($urandom));
      end
      id1 = 4'($urandom_range(1, 15));
      id2 = 4'(((int'(id1) - 1 + $urandom_range(1, 14)) % 15) + 1);
      do id3 = 4'($urandom_range(1, 15)); while (id3 == id1 || id3 == id2);
      valid_from_rs_cdb1 = ($urandom_range(0, 9) < 4);
      rob_id_from_rs_cdb1 = id1;
      result_from_rs_cdb1 = $urandom;
      valid_from_rs_cdb2 = ($urandom_range(0, 9) < 4);
      rob_id_from_rs_cdb2 = id2;
      result_from_rs_cdb2 = $urandom;
      valid_from_ls_cdb = ($urandom_range(0, 9) < 4);
      rob_id_from_ls_cdb = id3;
      result_from_ls_cdb = $urandom;
      tick();
    end
    idle();
    for (int i = 0; i < 5; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
